// File: rtl/light_period_monitor_pkg.sv
// light_period_monitor_pkg: shared state encoding and default timing for the light period monitor
package light_period_monitor_pkg;
   typedef enum logic [1:0] {SYNC = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;
   localparam int HALF_PERIOD_DEF = 51;
   localparam int TOLERANCE_DEF = 2;
   localparam int LOCK_N_DEF = 4;
   localparam int TIMEOUT_DEF = 4 * HALF_PERIOD_DEF;
   localparam int CW_DEF = 26;
endpackage

// File: rtl/light_period_monitor_edge_detector.sv
// light_period_monitor_edge_detector: registers light_in and flags any toggle against the registered copy
module light_period_monitor_edge_detector (
   input  logic clk,
   input  logic reset,
   input  logic light_in,
   output logic toggle
);
   logic light_q;
   // previous light value; resets low so a high light at release reads as an edge
   always_ff @(posedge clk or negedge reset)
      if (!reset) light_q <= 1'b0;
      else light_q <= light_in;
   assign toggle = light_in ^ light_q;
endmodule

// File: rtl/light_period_monitor.sv
// light_period_monitor: measures light half-periods, checks them against tolerance, tracks lock and sticky faults
module light_period_monitor
   import light_period_monitor_pkg::*;
#(
   parameter int HALF_PERIOD = HALF_PERIOD_DEF,
   parameter int TOLERANCE = TOLERANCE_DEF,
   parameter int LOCK_N = LOCK_N_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          light_in,
   input  logic          clr,
   output logic [1:0]    state,
   output logic          locked,
   output logic          fault,
   output logic          stuck,
   output logic          half_strobe,
   output logic [CW-1:0] last_half,
   output logic [15:0]   edge_count
);
   localparam int GW = $clog2(LOCK_N + 1);
   localparam logic [CW:0] HP = (CW+1)'(HALF_PERIOD);
   localparam logic [CW:0] TOL = (CW+1)'(TOLERANCE);
   localparam logic [CW:0] TO = (CW+1)'(TIMEOUT);
   localparam logic [GW-1:0] LN = GW'(LOCK_N);
   localparam logic [GW-1:0] LN1 = GW'(LOCK_N - 1);
   state_t st;
   logic [CW-1:0] cnt;
   logic [GW-1:0] good_run;
   logic [CW:0] meas, dev;
   logic toggle, good, timeout;
   light_period_monitor_edge_detector u_edge (
      .clk(clk),
      .reset(reset),
      .light_in(light_in),
      .toggle(toggle)
   );
   // meas is the length of the half-period ending this cycle; one extra bit keeps the deviation from wrapping
   assign meas = {1'b0, cnt} + 1'b1;
   assign dev = (meas >= HP) ? meas - HP : HP - meas;
   assign good = dev <= TOL;
   assign timeout = meas == TO;
   assign state = st;
   // half-period counter, edge tally and capture of each measured half outside SYNC
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt <= '0;
         last_half <= '0;
         edge_count <= '0;
         half_strobe <= 1'b0;
      end else begin
         cnt <= toggle ? '0 : (&cnt ? cnt : cnt + 1'b1);
         half_strobe <= toggle && st != SYNC;
         if (toggle) edge_count <= edge_count + 1'b1;
         if (toggle && st != SYNC) last_half <= meas[CW-1:0];
      end
   // lock/fault state machine; an edge takes priority over a coincident timeout
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         st <= SYNC;
         good_run <= '0;
         locked <= 1'b0;
         fault <= 1'b0;
         stuck <= 1'b0;
      end else begin
         case (st)
            SYNC: if (toggle) st <= TRACK;
            TRACK:
               if (toggle && good) begin
                  good_run <= (good_run == LN) ? good_run : good_run + 1'b1;
                  if (good_run >= LN1) locked <= 1'b1;
               end else if (toggle || timeout) begin
                  st <= FAULT;
                  fault <= 1'b1;
                  stuck <= !toggle;
                  locked <= 1'b0;
                  good_run <= '0;
               end
            FAULT:
               if (clr) begin
                  st <= SYNC;
                  fault <= 1'b0;
                  stuck <= 1'b0;
                  good_run <= '0;
               end
            default: st <= SYNC;
         endcase
      end
endmodule

// File: doc/light_period_monitor.md
Name: light_period_monitor

Overview:
- Downstream consumer of the blink counter's toggling light output.
- Samples the light signal and measures every half-period (the clk cycles between toggles).
- Checks each half-period against an expected value within a tolerance, tracks lock, and raises sticky fault and stuck flags.
- Used as an on-chip self-check of the blink counter and as a bench-visible health monitor.

Parameters:
- HALF_PERIOD, 51, expected clk cycles between consecutive light toggles (the counter's 0..50 wrap).
- TOLERANCE, 2, allowed absolute deviation, in cycles, of a measured half-period.
- LOCK_N, 4, consecutive in-tolerance half-periods required to assert locked.
- TIMEOUT, 204, cycles without an edge in TRACK that declare stuck (default 4*HALF_PERIOD).
- CW, 26, width of the half-period counter and of last_half.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- light_in  in  1  light output of the blink counter, same clock domain.
- clr  in  1  synchronous fault-clear pulse.
- state  out  2  current FSM state: 0=SYNC, 1=TRACK, 2=FAULT.
- locked  out  1  LOCK_N consecutive good half-periods seen since entering TRACK.
- fault  out  1  sticky; set by an out-of-tolerance half-period or by stuck.
- stuck  out  1  sticky; set by timeout.
- half_strobe  out  1  1-cycle pulse when last_half updates.
- last_half  out  CW  most recent measured half-period, in cycles.
- edge_count  out  16  total light edges since reset; wraps at 0xFFFF->0.

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-measurement) clears:
  - light_q, cnt, good_run, last_half, edge_count to 0;
  - locked, fault, stuck, half_strobe to 0;
  - state to SYNC.
- light_q is a register of light_in. An edge occurs in a cycle where light_in != light_q.
  - light_q resets to 0, so light_in=1 at reset release counts as an edge.
- cnt:
  - On an edge: cnt <= 0.
  - Otherwise: cnt <= cnt+1, saturating at all-ones.
  - meas = cnt+1, computed at CW+1 bits.
- On every edge:
  - edge_count increments, in any state.
  - Outside SYNC: last_half <= meas[CW-1:0] and half_strobe=1 next cycle.
- Tolerance check: compute |meas - HALF_PERIOD| at CW+1 bits with no underflow. Good means the result is <= TOLERANCE.
- SYNC: the first edge moves to TRACK with cnt=0. No measurement is taken and no timeout is checked.
- TRACK, on an edge:
  - Good: good_run++ (saturates at LOCK_N); locked=1 when good_run reaches LOCK_N. The edge that brings good_run to LOCK_N gives locked=1 on the following cycle.
  - Bad: fault=1, locked=0, good_run=0, go to FAULT.
- TRACK, no edge and meas==TIMEOUT: stuck=1, fault=1, locked=0, go to FAULT.
- FAULT:
  - Edges are still counted and last_half still updates. No lock evaluation.
  - clr=1 moves to SYNC and clears fault, stuck, good_run.
- clr in SYNC or TRACK has no effect.
- clr and an edge in the same FAULT cycle: clr wins and next state is SYNC. The edge is still counted and captured. The next edge starts TRACK.
- Edge and timeout in the same cycle: the edge wins; meas is judged by tolerance.
- Latency: every flag and output is registered, valid the cycle after the causing edge or timeout.

Decomposition:
- Shared package holds:
  - state encodings SYNC/TRACK/FAULT (2-bit);
  - HALF_PERIOD default 51, kept in sync with the blink counter's terminal count;
  - defaults for TOLERANCE, LOCK_N, TIMEOUT.
- One sub-module, edge_detector: registers light_in and outputs a 1-cycle edge pulse. It uses the same clk and active-low asynchronous reset.
- The FSM, cnt and checks live in the top module.

Test Plan:
- Nominal:
  - Stimulus: reset low 3 cycles; light_in toggles every 51 cycles.
  - Response: state=TRACK after the 1st edge; locked=1 the cycle after the 5th edge (4 good halves); last_half=51; fault=0.
- Tolerance boundary:
  - Stimulus: after lock, one half of 53.
  - Response: locked stays 1, last_half=53.
  - Then a half of 54: fault=1, locked=0, state=FAULT, stuck=0, last_half=54.
- Stuck:
  - Stimulus: in TRACK, hold light_in for 204 cycles.
  - Response: stuck=1, fault=1, state=FAULT; cnt keeps counting; edge_count unchanged.
- Clear:
  - Stimulus: in FAULT, pulse clr together with a light_in edge.
  - Response: next state=SYNC, fault=0, stuck=0, edge_count+1. The next edge gives TRACK; 4 nominal halves relock.
- Async reset mid-run:
  - Stimulus: drop reset between clk edges while locked.
  - Response: all outputs 0 and state=SYNC immediately, before the next clk. With light_in=1 at release, the first clk counts edge_count=1.
- Wrap:
  - Stimulus: preload by running 65536 edges (fast toggling, tolerance ignored).
  - Response: edge_count returns to 0.
